// File: rtl/axis_stream_monitor.sv
// axis_stream_monitor: zero-latency AXI-Stream pass-through with per-channel
// beat/packet counters, snapshot/clear control and a windowed beat-rate figure.
// Optional build macro: AXIS_MON_STALL_CNT_EN adds per-channel stall counters;
// without it stall_cnt is tied to zero.
module axis_stream_monitor #(
  parameter int CHANNELS      = 2,
  parameter int DATA_WIDTH    = 512,
  parameter int USER_WIDTH    = 137,
  parameter int CNT_WIDTH     = 32,
  parameter int WINDOW_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [CHANNELS*DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [CHANNELS*USER_WIDTH-1:0]   s_axis_tuser,
  input  logic [CHANNELS-1:0]              s_axis_tlast,
  input  logic [CHANNELS-1:0]              s_axis_tvalid,
  output logic [CHANNELS-1:0]              s_axis_tready,
  output logic [CHANNELS*DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [CHANNELS*DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [CHANNELS*USER_WIDTH-1:0]   m_axis_tuser,
  output logic [CHANNELS-1:0]              m_axis_tlast,
  output logic [CHANNELS-1:0]              m_axis_tvalid,
  input  logic [CHANNELS-1:0]              m_axis_tready,
  input  logic                             snap_req,
  input  logic                             clr_req,
  output logic [CHANNELS*CNT_WIDTH-1:0]    beat_cnt,
  output logic [CHANNELS*CNT_WIDTH-1:0]    pkt_cnt,
  output logic [CHANNELS*CNT_WIDTH-1:0]    rate_cnt,
  output logic                             rate_valid,
  output logic [CHANNELS*CNT_WIDTH-1:0]    stall_cnt
);

  localparam int                   WIN_W    = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic en);
    if (en && (v != CNT_MAX)) return v + CNT_WIDTH'(1);
    return v;
  endfunction

  // The data path is a pure wire copy; the monitor never alters or stalls traffic.
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tuser  = s_axis_tuser;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tvalid = s_axis_tvalid;
  assign s_axis_tready = m_axis_tready;

  logic [WIN_W-1:0] r_win_cnt;
  logic             r_rate_valid;
  logic             w_win_last;

  assign w_win_last = (r_win_cnt == WIN_LAST);
  assign rate_valid = r_rate_valid;

  // Free-running window cycle counter, shared by all channels.
  always_ff @(posedge clk) begin
    if (rst || w_win_last) r_win_cnt <= '0;
    else                   r_win_cnt <= r_win_cnt + WIN_W'(1);
  end

  // rate_valid pulses in the cycle after the last window cycle.
  always_ff @(posedge clk) begin
    if (rst) r_rate_valid <= 1'b0;
    else     r_rate_valid <= w_win_last;
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic                 w_acc;
      logic [CNT_WIDTH-1:0] w_beat_next, w_pkt_next, w_win_next;
      logic [CNT_WIDTH-1:0] r_beat, r_pkt, r_win_beats;
      logic [CNT_WIDTH-1:0] r_beat_snap, r_pkt_snap, r_rate;

      assign w_acc       = s_axis_tvalid[gi] & m_axis_tready[gi];
      assign w_beat_next = sat_inc(r_beat, w_acc);
      assign w_pkt_next  = sat_inc(r_pkt, w_acc & s_axis_tlast[gi]);
      assign w_win_next  = sat_inc(r_win_beats, w_acc);

      // Live beat/packet counters; clear discards a same-cycle beat.
      always_ff @(posedge clk) begin
        if (rst || clr_req) begin
          r_beat <= '0;
          r_pkt  <= '0;
        end else begin
          r_beat <= w_beat_next;
          r_pkt  <= w_pkt_next;
        end
      end

      // Window beat accumulator and its published rate; untouched by clear.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_win_beats <= '0;
          r_rate      <= '0;
        end else if (w_win_last) begin
          r_win_beats <= '0;
          r_rate      <= w_win_next;
        end else begin
          r_win_beats <= w_win_next;
        end
      end

      // Snapshot captures the value including this cycle's beat (pre-clear).
      always_ff @(posedge clk) begin
        if (rst) begin
          r_beat_snap <= '0;
          r_pkt_snap  <= '0;
        end else if (snap_req) begin
          r_beat_snap <= w_beat_next;
          r_pkt_snap  <= w_pkt_next;
        end
      end

      assign beat_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = r_beat_snap;
      assign pkt_cnt[gi*CNT_WIDTH +: CNT_WIDTH]  = r_pkt_snap;
      assign rate_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = r_rate;

`ifdef AXIS_MON_STALL_CNT_EN
      logic                 w_stall;
      logic [CNT_WIDTH-1:0] w_stall_next, r_stall, r_stall_snap;

      assign w_stall      = s_axis_tvalid[gi] & ~m_axis_tready[gi];
      assign w_stall_next = sat_inc(r_stall, w_stall);

      // Live stall counter: valid offered while downstream is not ready.
      always_ff @(posedge clk) begin
        if (rst || clr_req) r_stall <= '0;
        else                r_stall <= w_stall_next;
      end

      // Stall snapshot, same capture rule as the beat snapshot.
      always_ff @(posedge clk) begin
        if (rst)           r_stall_snap <= '0;
        else if (snap_req) r_stall_snap <= w_stall_next;
      end

      assign stall_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = r_stall_snap;
`else
      assign stall_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = '0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_axis_stream_monitor.sv
// Testbench for axis_stream_monitor: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// count-based behavioural model. Two instances share stimulus; the second
// uses 4-bit counters to exercise saturation.
module tb_axis_stream_monitor;

  localparam int CH  = 2;
  localparam int DW  = 32;
  localparam int KW  = DW / 8;
  localparam int UW  = 5;
  localparam int WIN = 16;
  localparam int CWA = 16;
  localparam int CWB = 4;
  localparam longint MAXA = (64'd1 << CWA) - 1;
  localparam longint MAXB = (64'd1 << CWB) - 1;
`ifdef AXIS_MON_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, snap, clr;
  logic [CH*DW-1:0]  tdata;
  logic [CH*KW-1:0]  tkeep;
  logic [CH*UW-1:0]  tuser;
  logic [CH-1:0]     tlast, tvalid, m_ready;

  logic [CH*DW-1:0]  a_tdata, b_tdata;
  logic [CH*KW-1:0]  a_tkeep, b_tkeep;
  logic [CH*UW-1:0]  a_tuser, b_tuser;
  logic [CH-1:0]     a_tlast, b_tlast, a_tvalid, b_tvalid, a_tready, b_tready;
  logic [CH*CWA-1:0] a_beat, a_pkt, a_rate, a_stall;
  logic [CH*CWB-1:0] b_beat, b_pkt, b_rate, b_stall;
  logic              a_rv, b_rv;

  axis_stream_monitor #(.CHANNELS(CH), .DATA_WIDTH(DW), .USER_WIDTH(UW),
                        .CNT_WIDTH(CWA), .WINDOW_CYCLES(WIN)) dut_a (
    .clk(clk), .rst(rst),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tuser(tuser),
    .s_axis_tlast(tlast), .s_axis_tvalid(tvalid), .s_axis_tready(a_tready),
    .m_axis_tdata(a_tdata), .m_axis_tkeep(a_tkeep), .m_axis_tuser(a_tuser),
    .m_axis_tlast(a_tlast), .m_axis_tvalid(a_tvalid), .m_axis_tready(m_ready),
    .snap_req(snap), .clr_req(clr),
    .beat_cnt(a_beat), .pkt_cnt(a_pkt), .rate_cnt(a_rate),
    .rate_valid(a_rv), .stall_cnt(a_stall));

  axis_stream_monitor #(.CHANNELS(CH), .DATA_WIDTH(DW), .USER_WIDTH(UW),
                        .CNT_WIDTH(CWB), .WINDOW_CYCLES(WIN)) dut_b (
    .clk(clk), .rst(rst),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tuser(tuser),
    .s_axis_tlast(tlast), .s_axis_tvalid(tvalid), .s_axis_tready(b_tready),
    .m_axis_tdata(b_tdata), .m_axis_tkeep(b_tkeep), .m_axis_tuser(b_tuser),
    .m_axis_tlast(b_tlast), .m_axis_tvalid(b_tvalid), .m_axis_tready(m_ready),
    .snap_req(snap), .clr_req(clr),
    .beat_cnt(b_beat), .pkt_cnt(b_pkt), .rate_cnt(b_rate),
    .rate_valid(b_rv), .stall_cnt(b_stall));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input longint m);
    return (v > m) ? m : v;
  endfunction

  // ---------------- behavioural model: raw event totals ----------------
  longint tot_beat[CH], tot_pkt[CH], tot_stall[CH], win_beats[CH];
  longint sn_beat[CH], sn_pkt[CH], sn_stall[CH], rate_raw[CH];
  bit     exp_rv;
  int     t_since_rst;
  bit     model_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        tot_beat[c] = 0; tot_pkt[c] = 0; tot_stall[c] = 0; win_beats[c] = 0;
        sn_beat[c] = 0; sn_pkt[c] = 0; sn_stall[c] = 0; rate_raw[c] = 0;
      end
      exp_rv = 1'b0;
      t_since_rst = 0;
      model_ok = 1'b1;
    end else begin
      bit end_of_window;
      end_of_window = ((t_since_rst % WIN) == WIN - 1);
      for (int c = 0; c < CH; c++) begin
        longint acc, nb, np, ns;
        acc = (tvalid[c] && m_ready[c]) ? 1 : 0;
        nb  = tot_beat[c] + acc;
        np  = tot_pkt[c] + ((acc == 1 && tlast[c]) ? 1 : 0);
        ns  = tot_stall[c] + ((STALL_EN && tvalid[c] && !m_ready[c]) ? 1 : 0);
        if (snap) begin sn_beat[c] = nb; sn_pkt[c] = np; sn_stall[c] = ns; end
        if (clr) begin
          tot_beat[c] = 0; tot_pkt[c] = 0; tot_stall[c] = 0;
        end else begin
          tot_beat[c] = nb; tot_pkt[c] = np; tot_stall[c] = ns;
        end
        if (end_of_window) begin
          rate_raw[c]  = win_beats[c] + acc;
          win_beats[c] = 0;
        end else begin
          win_beats[c] = win_beats[c] + acc;
        end
      end
      exp_rv = end_of_window;
      t_since_rst++;
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    chk("pass_data_a", {a_tdata, a_tkeep, a_tuser}, {tdata, tkeep, tuser});
    chk("pass_ctl_a",  {a_tlast, a_tvalid, a_tready}, {tlast, tvalid, m_ready});
    chk("pass_data_b", {b_tdata, b_tkeep, b_tuser}, {tdata, tkeep, tuser});
    chk("pass_ctl_b",  {b_tlast, b_tvalid, b_tready}, {tlast, tvalid, m_ready});
    if (model_ok) begin
      chk("rate_valid_a", a_rv, exp_rv);
      chk("rate_valid_b", b_rv, exp_rv);
      for (int c = 0; c < CH; c++) begin
        chk($sformatf("beat_a[%0d]", c),  a_beat[c*CWA +: CWA],  sat(sn_beat[c], MAXA));
        chk($sformatf("pkt_a[%0d]", c),   a_pkt[c*CWA +: CWA],   sat(sn_pkt[c], MAXA));
        chk($sformatf("rate_a[%0d]", c),  a_rate[c*CWA +: CWA],  sat(rate_raw[c], MAXA));
        chk($sformatf("stall_a[%0d]", c), a_stall[c*CWA +: CWA], sat(sn_stall[c], MAXA));
        chk($sformatf("beat_b[%0d]", c),  b_beat[c*CWB +: CWB],  sat(sn_beat[c], MAXB));
        chk($sformatf("pkt_b[%0d]", c),   b_pkt[c*CWB +: CWB],   sat(sn_pkt[c], MAXB));
        chk($sformatf("rate_b[%0d]", c),  b_rate[c*CWB +: CWB],  sat(rate_raw[c], MAXB));
        chk($sformatf("stall_b[%0d]", c), b_stall[c*CWB +: CWB], sat(sn_stall[c], MAXB));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Controls set before cyc() are sampled at its clock edge; pulses self-clear.
  task automatic cyc();
    @(posedge clk);
    #1;
    tdata = {$urandom, $urandom};
    tkeep = CH*KW'($urandom);
    tuser = CH*UW'($urandom);
    snap  = 1'b0;
    clr   = 1'b0;
  endtask

  // Advance until rate_valid is seen, at most 40 cycles.
  task automatic wait_rv(output bit found, output int n);
    found = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      n++;
      if (a_rv) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rv_timeout got=none exp=pulse within 40 cycles t=%0t", $time);
    end
  endtask

  initial begin
    bit found;
    int n;
    rst = 1'b1; snap = 1'b0; clr = 1'b0;
    tdata = '0; tkeep = '0; tuser = '0;
    tlast = '0; tvalid = '0; m_ready = '0;
    repeat (3) cyc();
    $display("txn reset: beat_a0=%0d rate_valid=%0d", a_beat[0 +: CWA], a_rv);
    chk("lit_reset_beat", a_beat, '0);
    chk("lit_reset_rv", a_rv, 1'b0);
    rst = 1'b0;

    // 10 beats on ch0, tlast on beats 5 and 10
    m_ready = 2'b11;
    for (int i = 1; i <= 10; i++) begin
      tvalid[0] = 1'b1;
      tlast[0]  = (i == 5 || i == 10);
      cyc();
    end
    tvalid = '0; tlast = '0; snap = 1'b1;
    cyc();
    $display("txn ten_beats: beat0=%0d pkt0=%0d beat1=%0d", a_beat[0 +: CWA], a_pkt[0 +: CWA], a_beat[CWA +: CWA]);
    chk("lit_beat10", a_beat[0 +: CWA], 10);
    chk("lit_pkt2", a_pkt[0 +: CWA], 2);
    chk("lit_ch1_zero", {a_beat[CWA +: CWA], a_pkt[CWA +: CWA]}, '0);

    // valid 8 cycles, ready low on 3 of them
    clr = 1'b1;
    cyc();
    for (int i = 0; i < 8; i++) begin
      tvalid[0]  = 1'b1;
      m_ready[0] = !(i == 1 || i == 4 || i == 6);
      cyc();
    end
    tvalid = '0; m_ready = 2'b11; snap = 1'b1;
    cyc();
    $display("txn stall: beat0=%0d stall0=%0d", a_beat[0 +: CWA], a_stall[0 +: CWA]);
    chk("lit_beat5", a_beat[0 +: CWA], 5);
    chk("lit_stall", a_stall[0 +: CWA], STALL_EN ? 3 : 0);

    // snap+clr together on the 8th beat
    clr = 1'b1;
    cyc();
    tvalid[0] = 1'b1;
    repeat (7) cyc();
    snap = 1'b1; clr = 1'b1;
    cyc();
    tvalid = '0;
    $display("txn snap_clr: beat0=%0d", a_beat[0 +: CWA]);
    chk("lit_snapclr_8", a_beat[0 +: CWA], 8);
    snap = 1'b1;
    cyc();
    $display("txn snap_after_clr: beat0=%0d", a_beat[0 +: CWA]);
    chk("lit_after_clr_0", a_beat[0 +: CWA], 0);

    // rate window: ch1 continuously accepted
    tvalid[1] = 1'b1;
    wait_rv(found, n);
    wait_rv(found, n);
    $display("txn rate: gap=%0d rate_a1=%0d rate_b1=%0d", n, a_rate[CWA +: CWA], b_rate[CWB +: CWB]);
    chk("lit_rv_period", n, WIN);
    chk("lit_rate16", a_rate[CWA +: CWA], 16);
    chk("lit_rate_sat", b_rate[CWB +: CWB], 15);
    tvalid[1] = 1'b0;
    wait_rv(found, n);
    wait_rv(found, n);
    $display("txn rate_idle: rate_a1=%0d", a_rate[CWA +: CWA]);
    chk("lit_rate0", a_rate[CWA +: CWA], 0);

    // saturation: 20 beats
    clr = 1'b1;
    cyc();
    tvalid[0] = 1'b1; tlast[0] = 1'b1;
    repeat (20) cyc();
    tvalid = '0; tlast = '0; snap = 1'b1;
    cyc();
    $display("txn saturate: beat_a0=%0d beat_b0=%0d pkt_b0=%0d", a_beat[0 +: CWA], b_beat[0 +: CWB], b_pkt[0 +: CWB]);
    chk("lit_beat20", a_beat[0 +: CWA], 20);
    chk("lit_beat_sat15", b_beat[0 +: CWB], 15);
    chk("lit_pkt_sat15", b_pkt[0 +: CWB], 15);

    // reset mid-packet
    clr = 1'b1;
    cyc();
    tvalid[0] = 1'b1;
    repeat (6) cyc();
    rst = 1'b1;
    cyc();
    chk("lit_rv_in_rst", a_rv, 1'b0);
    rst = 1'b0;
    repeat (2) begin
      cyc();
      chk("lit_rv_after_rst", a_rv, 1'b0);
    end
    tvalid = '0; snap = 1'b1;
    cyc();
    $display("txn reset_mid: beat0=%0d pkt0=%0d", a_beat[0 +: CWA], a_pkt[0 +: CWA]);
    chk("lit_beat_after_rst", a_beat[0 +: CWA], 2);
    chk("lit_pkt_after_rst", a_pkt[0 +: CWA], 0);

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 500; i++) begin
      tvalid  = CH'($urandom);
      m_ready = CH'($urandom);
      tlast   = CH'($urandom);
      snap    = ($urandom_range(0, 7) == 0);
      clr     = ($urandom_range(0, 23) == 0);
      rst     = ($urandom_range(0, 149) == 0);
      cyc();
      if (i % 50 == 49)
        $display("txn random[%0d]: beat_a=%0h pkt_a=%0h rate_a=%0h", i, a_beat, a_pkt, a_rate);
    end
    rst = 1'b0; tvalid = '0;
    repeat (2) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_stream_monitor.md
# axis_stream_monitor

Parametrised multi-channel AXI-Stream pass-through monitor for the Zynq PCIe/NIC datapath. Each channel forwards the stream combinationally and counts accepted beats and packets; it also produces a per-window beat-rate figure for software throughput sampling. It is inserted inline on RQ/CC-style streams between a producer and a consumer, adds zero latency to the data path and exports coherent, software-visible statistics.

## Interface
Parameters:
- CHANNELS, 2, number of independent monitored streams
- DATA_WIDTH, 512, tdata width per channel (multiple of 8)
- USER_WIDTH, 137, tuser width per channel (common to all channels)
- CNT_WIDTH, 32, width of every counter
- WINDOW_CYCLES, 1024, rate window length in clk cycles (>= 2)

Ports (per-channel buses are flattened, channel i at [i*W +: W]):
- clk  in  1  sole clock
- rst  in  1  synchronous reset, active-high
- s_axis_tdata  in  CHANNELS*DATA_WIDTH  upstream data
- s_axis_tkeep  in  CHANNELS*DATA_WIDTH/8  upstream byte enables
- s_axis_tuser  in  CHANNELS*USER_WIDTH  upstream sideband
- s_axis_tlast  in  CHANNELS  end of packet
- s_axis_tvalid  in  CHANNELS  upstream valid
- s_axis_tready  out  CHANNELS  = m_axis_tready
- m_axis_tdata/tkeep/tuser/tlast/tvalid  out  as s_axis_*  downstream copies
- m_axis_tready  in  CHANNELS  downstream ready
- snap_req  in  1  one-cycle pulse: latch all live counters into snapshot outputs
- clr_req  in  1  one-cycle pulse: zero all live counters
- beat_cnt  out  CHANNELS*CNT_WIDTH  snapshot of accepted beats
- pkt_cnt  out  CHANNELS*CNT_WIDTH  snapshot of accepted tlast beats
- rate_cnt  out  CHANNELS*CNT_WIDTH  beats accepted in last completed window
- rate_valid  out  1  one-cycle pulse when rate_cnt updates
- stall_cnt  out  CHANNELS*CNT_WIDTH  snapshot of stall cycles (see Configuration)

## Operation
- Data path: all m_axis_* = s_axis_*, s_axis_tready = m_axis_tready, purely combinational; monitor never back-pressures or alters data.
- Beat accepted on channel i when s_axis_tvalid[i] && m_axis_tready[i]. Valid alone is not counted.
- Live counters per channel: beats (+1 per accepted beat), packets (+1 per accepted beat with tlast), window beats.
- All counters saturate at 2^CNT_WIDTH-1; no wrap.
- Window: free-running cycle counter 0..WINDOW_CYCLES-1. On the cycle it reads WINDOW_CYCLES-1: rate_cnt[i] <= window beats including that cycle's beat; window beats restart at 0; rate_valid = 1 next cycle for one cycle; counter wraps to 0.
- snap_req: beat_cnt/pkt_cnt/stall_cnt <= live value including the beat accepted in the same cycle.
- clr_req: live beat/packet/stall counters <= 0; a beat accepted in the same cycle is discarded. Window counter and rate path unaffected.
- snap_req with clr_req in same cycle: snapshot captures pre-clear value (including same-cycle beat), then live counters zero.
- Reset: all live counters, window counter, beat_cnt, pkt_cnt, rate_cnt, stall_cnt = 0, rate_valid = 0. Pass-through outputs follow inputs during reset. Reset mid-packet discards partial counts; no recovery of pre-reset values.

## Timing
- Data path latency 0 cycles.
- Snapshot outputs update 1 cycle after snap_req (registered).
- rate_cnt and rate_valid registered; rate_valid asserted exactly once per WINDOW_CYCLES cycles, first at cycle WINDOW_CYCLES after reset release.
- Counter increment visible in live state 1 cycle after handshake.

## Configuration
- AXIS_MON_STALL_CNT_EN defined: per-channel live stall counter increments on each cycle s_axis_tvalid[i] && !m_axis_tready[i], saturating, cleared by clr_req, snapshotted by snap_req into stall_cnt.
- Not defined: stall logic not built; stall_cnt tied to 0.

## Test plan
- 10 beats on ch0 with ready high, tlast on beats 5 and 10, then snap_req -> beat_cnt[0]=10, pkt_cnt[0]=2, ch1 counts 0, outputs bit-identical to inputs.
- Valid high 8 cycles, ready low 3 of them, then snap_req -> beat_cnt=5; with AXIS_MON_STALL_CNT_EN stall_cnt=3, without it 0.
- WINDOW_CYCLES=16, ch1 continuously accepted -> rate_valid pulses every 16 cycles, rate_cnt[1]=16; after traffic stops the next window reports 0.
- snap_req and clr_req same cycle as accepted beat after 7 prior beats -> beat_cnt=8, next snapshot with no traffic gives 0.
- CNT_WIDTH=4, 20 accepted beats -> beat_cnt=15 (saturated), no wrap.
- rst asserted mid-packet after 6 beats for 1 cycle, then 2 beats and snap_req -> beat_cnt=2, rate_valid low during and right after reset.
